// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data sram-like ports onto one single-beat, one-outstanding AXI3 master.
// Define SRAM_AXI_BRIDGE_MMU_EN to fold kseg0/kseg1 addresses down to physical on araddr/awaddr.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    output logic        stallreq,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE, D_AR, D_R, D_W, D_B, I_AR, I_R, DONE
    } state_t;

    state_t      state, state_d;
    logic        inst_ok, inst_ok_d;
    logic        data_ok, data_ok_d;
    logic        cur_inst, cur_inst_d;
    logic        arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
    logic [3:0]  arid_d;
    logic [31:0] araddr_d, awaddr_d, wdata_d;
    logic [3:0]  wstrb_d;
    logic [31:0] inst_rdata_d, data_rdata_d;
    logic        inst_pend, data_pend;
    logic        launch, launch_inst;
    logic [3:0]  sel_wen;
    logic [31:0] sel_addr, sel_wdata;
    logic        unused_ok;

    // Fixed single-beat, word-sized, uncached attributes
    assign arlen   = 4'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = DATA_ID;
    assign awlen   = 4'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = DATA_ID;
    assign wlast   = 1'b1;

    assign unused_ok = ^{rresp, rlast, bid, bresp};

    function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef SRAM_AXI_BRIDGE_MMU_EN
        map_addr = (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
`else
        map_addr = a;
`endif
    endfunction

    assign inst_pend = inst_sram_en & ~inst_ok;
    assign data_pend = data_sram_en & ~data_ok;
    assign stallreq  = inst_pend | data_pend;

    assign sel_wen   = launch_inst ? inst_sram_wen   : data_sram_wen;
    assign sel_addr  = launch_inst ? inst_sram_addr  : data_sram_addr;
    assign sel_wdata = launch_inst ? inst_sram_wdata : data_sram_wdata;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            inst_ok         <= 1'b0;
            data_ok         <= 1'b0;
            cur_inst        <= 1'b0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            awvalid         <= 1'b0;
            wvalid          <= 1'b0;
            bready          <= 1'b0;
            arid            <= 4'd0;
            araddr          <= 32'd0;
            awaddr          <= 32'd0;
            wdata           <= 32'd0;
            wstrb           <= 4'd0;
            inst_sram_rdata <= 32'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            state           <= state_d;
            inst_ok         <= inst_ok_d;
            data_ok         <= data_ok_d;
            cur_inst        <= cur_inst_d;
            arvalid         <= arvalid_d;
            rready          <= rready_d;
            awvalid         <= awvalid_d;
            wvalid          <= wvalid_d;
            bready          <= bready_d;
            arid            <= arid_d;
            araddr          <= araddr_d;
            awaddr          <= awaddr_d;
            wdata           <= wdata_d;
            wstrb           <= wstrb_d;
            inst_sram_rdata <= inst_rdata_d;
            data_sram_rdata <= data_rdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        inst_ok_d    = inst_ok;
        data_ok_d    = data_ok;
        cur_inst_d   = cur_inst;
        arvalid_d    = arvalid;
        rready_d     = rready;
        awvalid_d    = awvalid;
        wvalid_d     = wvalid;
        bready_d     = bready;
        arid_d       = arid;
        araddr_d     = araddr;
        awaddr_d     = awaddr;
        wdata_d      = wdata;
        wstrb_d      = wstrb;
        inst_rdata_d = inst_sram_rdata;
        data_rdata_d = data_sram_rdata;
        launch       = 1'b0;
        launch_inst  = 1'b0;

        case (state)
            IDLE: begin
                if (data_pend) begin
                    launch = 1'b1;
                end else if (inst_pend) begin
                    launch      = 1'b1;
                    launch_inst = 1'b1;
                end
            end
            D_AR, I_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = (state == D_AR) ? D_R : I_R;
                end
            end
            D_R: begin
                if (rvalid && rid == arid) begin
                    rready_d  = 1'b0;
                    data_ok_d = data_sram_en;
                    if (data_sram_en) data_rdata_d = rdata;
                    if (inst_pend) begin
                        launch      = 1'b1;
                        launch_inst = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            I_R: begin
                if (rvalid && rid == arid) begin
                    rready_d  = 1'b0;
                    inst_ok_d = inst_sram_en;
                    if (inst_sram_en) inst_rdata_d = rdata;
                    state_d = DONE;
                end
            end
            D_W: begin
                // AW and W complete independently; respond only once both are accepted
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    bready_d = 1'b1;
                    state_d  = D_B;
                end
            end
            D_B: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    if (cur_inst) begin
                        inst_ok_d = inst_sram_en;
                        state_d   = DONE;
                    end else begin
                        data_ok_d = data_sram_en;
                        if (inst_pend) begin
                            launch      = 1'b1;
                            launch_inst = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                inst_ok_d = 1'b0;
                data_ok_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Start the next access; inst writes share the data write path and ID
        if (launch) begin
            cur_inst_d = launch_inst;
            if (sel_wen != 4'd0) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = map_addr(sel_addr);
                wdata_d   = sel_wdata;
                wstrb_d   = sel_wen;
                state_d   = D_W;
            end else begin
                arvalid_d = 1'b1;
                araddr_d  = map_addr(sel_addr);
                arid_d    = launch_inst ? INST_ID : DATA_ID;
                state_d   = launch_inst ? I_AR : D_AR;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; expected addresses follow SRAM_AXI_BRIDGE_MMU_EN when defined.
module tb_sram_axi_bridge;

    logic        clk, rst;
    logic        inst_sram_en, data_sram_en;
    logic [3:0]  inst_sram_wen, data_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        stallreq;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int vectors = 0;
    int miscompares = 0;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq(stallreq),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_map(input logic [31:0] a);
`ifdef SRAM_AXI_BRIDGE_MMU_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    // Control snapshot {arvalid, rready, awvalid, wvalid, bready, stallreq}
    function automatic logic [31:0] ctl();
        return 32'({arvalid, rready, awvalid, wvalid, bready, stallreq});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        inst_sram_en = 1'b0; inst_sram_wen = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

        // 1) reset, before and after the first edge
        #1 rst = 1'b1;
        #1;
        chk("rst_ctl", ctl(), 32'b000000);
        chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
        chk("rst_data_rdata", data_sram_rdata, 32'd0);
        inst_sram_en = 1'b1;
        #1;
        chk("rst_stall_en", ctl(), 32'b000001);
        step();
        chk("rst_edge_ctl", ctl(), 32'b000001);
        rst = 1'b0;
        inst_sram_en = 1'b0;
        step();
        chk("idle_ctl", ctl(), 32'b000000);

        // 2) inst read, slave answers three cycles after the AR handshake
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000;
        step();
        chk("t2_ar_ctl", ctl(), 32'b100001);
        chk("t2_araddr", araddr, exp_map(32'hBFC0_0000));
        chk("t2_arid", 32'(arid), 32'd0);
        chk("t2_attr", 32'({arlen, arsize, arburst}), 32'({4'd0, 3'b010, 2'b01}));
        arready = 1'b1;
        step();
        chk("t2_r_ctl", ctl(), 32'b010001);
        arready = 1'b0;
        step();
        chk("t2_wait1", ctl(), 32'b010001);
        step();
        chk("t2_wait2", ctl(), 32'b010001);
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C08_0001;
        step();
        rvalid = 1'b0;
        chk("t2_done_ctl", ctl(), 32'b000000);
        chk("t2_rdata", inst_sram_rdata, 32'h3C08_0001);
        inst_sram_en = 1'b0;
        step();
        chk("t2_idle", ctl(), 32'b000000);

        // 3) inst and data read together: data first, inst chained straight after
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0004;
        data_sram_en = 1'b1; data_sram_addr = 32'h8000_0010;
        step();
        chk("t3_dar_ctl", ctl(), 32'b100001);
        chk("t3_dar_addr", araddr, exp_map(32'h8000_0010));
        chk("t3_dar_id", 32'(arid), 32'd1);
        arready = 1'b1;
        step();
        chk("t3_dr_ctl", ctl(), 32'b010001);
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_DEAD;
        step();
        chk("t3_badid_ctl", ctl(), 32'b010001);
        chk("t3_badid_rdata", data_sram_rdata, 32'd0);
        rid = 4'd1; rdata = 32'h1111_2222;
        step();
        rvalid = 1'b0;
        chk("t3_iar_ctl", ctl(), 32'b100001);
        chk("t3_iar_addr", araddr, exp_map(32'hBFC0_0004));
        chk("t3_iar_id", 32'(arid), 32'd0);
        chk("t3_data_rdata", data_sram_rdata, 32'h1111_2222);
        arready = 1'b1;
        step();
        chk("t3_ir_ctl", ctl(), 32'b010001);
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h2222_3333;
        step();
        rvalid = 1'b0;
        chk("t3_done_ctl", ctl(), 32'b000000);
        chk("t3_inst_rdata", inst_sram_rdata, 32'h2222_3333);
        inst_sram_en = 1'b0; data_sram_en = 1'b0;
        step();
        chk("t3_idle", ctl(), 32'b000000);

        // 4) data write, awready two cycles after wready
        data_sram_en = 1'b1; data_sram_wen = 4'b0011;
        data_sram_addr = 32'h0000_1000; data_sram_wdata = 32'hDEAD_BEEF;
        step();
        chk("t4_aw_ctl", ctl(), 32'b001101);
        chk("t4_awaddr", awaddr, 32'h0000_1000);
        chk("t4_wdata", wdata, 32'hDEAD_BEEF);
        chk("t4_wstrb", 32'(wstrb), 32'b0011);
        chk("t4_ids", 32'({awid, wid, wlast}), 32'({4'd1, 4'd1, 1'b1}));
        wready = 1'b1;
        step();
        chk("t4_w_done", ctl(), 32'b001001);
        wready = 1'b0;
        step();
        chk("t4_aw_hold", ctl(), 32'b001001);
        chk("t4_awaddr_hold", awaddr, 32'h0000_1000);
        awready = 1'b1;
        step();
        chk("t4_b_ctl", ctl(), 32'b000011);
        awready = 1'b0;
        bvalid = 1'b1; bid = 4'd1;
        step();
        bvalid = 1'b0;
        chk("t4_done_ctl", ctl(), 32'b000000);
        data_sram_en = 1'b0; data_sram_wen = 4'd0;
        step();
        chk("t4_idle", ctl(), 32'b000000);

        // 5) AR held off for ten cycles
        data_sram_en = 1'b1; data_sram_addr = 32'h0000_2000;
        step();
        chk("t5_ar_ctl", ctl(), 32'b100001);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_ar_hold_ctl", ctl(), 32'b100001);
            chk("t5_ar_hold_addr", araddr, 32'h0000_2000);
        end
        arready = 1'b1;
        step();
        chk("t5_r_ctl", ctl(), 32'b010001);
        arready = 1'b0;

        // 6) reset while waiting for R, then the read is reissued
        rst = 1'b1;
        #1;
        chk("t6_async_ctl", ctl(), 32'b000001);
        step();
        chk("t6_rst_ctl", ctl(), 32'b000001);
        chk("t6_rst_rdata", data_sram_rdata, 32'd0);
        rst = 1'b0;
        step();
        chk("t6_reissue_ctl", ctl(), 32'b100001);
        chk("t6_reissue_addr", araddr, 32'h0000_2000);
        arready = 1'b1;
        step();
        chk("t6_r_ctl", ctl(), 32'b010001);
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hCAFE_F00D;
        step();
        rvalid = 1'b0;
        chk("t6_done_ctl", ctl(), 32'b000000);
        chk("t6_rdata", data_sram_rdata, 32'hCAFE_F00D);
        data_sram_en = 1'b0;
        step();
        chk("t6_idle", ctl(), 32'b000000);

        // 7) kseg2 address passes through; en dropped mid-flight discards the result
        data_sram_en = 1'b1; data_sram_addr = 32'hC000_0004;
        step();
        chk("t7_ar_ctl", ctl(), 32'b100001);
        chk("t7_araddr", araddr, exp_map(32'hC000_0004));
        arready = 1'b1;
        step();
        chk("t7_r_ctl", ctl(), 32'b010001);
        arready = 1'b0;
        data_sram_en = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0055;
        step();
        rvalid = 1'b0;
        chk("t7_done_ctl", ctl(), 32'b000000);
        chk("t7_discard", data_sram_rdata, 32'hCAFE_F00D);
        step();
        chk("t7_idle", ctl(), 32'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
